// File: rtl/micro_pkg.sv
// -----------------------------------------------------------------------------
// micro_pkg
// Shared definitions for the 8-bit teaching microprocessor control unit:
// opcodes, internal-bus source selects, jump condition codes, ALU flag bit
// positions and the jump-condition helper used by the decoder.
// -----------------------------------------------------------------------------
package micro_pkg;

  // Opcodes live in instruction bits [8:6]
  localparam logic [2:0] OP_LOAD_IMM  = 3'b000;
  localparam logic [2:0] OP_LOAD_MEM  = 3'b001;
  localparam logic [2:0] OP_STORE_IMM = 3'b010;
  localparam logic [2:0] OP_STORE_REG = 3'b011;
  localparam logic [2:0] OP_MOVE      = 3'b100;
  localparam logic [2:0] OP_MATH      = 3'b101;
  localparam logic [2:0] OP_JUMP      = 3'b110;
  localparam logic [2:0] OP_NOP       = 3'b111;

  // Internal bus sources
  localparam logic [1:0] BUS_IMM = 2'b00;
  localparam logic [1:0] BUS_REG = 2'b01;
  localparam logic [1:0] BUS_MEM = 2'b10;
  localparam logic [1:0] BUS_ALU = 2'b11;

  // Jump condition codes (instruction bits [2:0] of a jump)
  localparam logic [2:0] COND_ALWAYS = 3'b000;
  localparam logic [2:0] COND_Z      = 3'b001;
  localparam logic [2:0] COND_C      = 3'b010;
  localparam logic [2:0] COND_N      = 3'b011;
  localparam logic [2:0] COND_NZ     = 3'b100;
  localparam logic [2:0] COND_NC     = 3'b101;
  localparam logic [2:0] COND_NN     = 3'b110;
  localparam logic [2:0] COND_NEVER  = 3'b111;

  // Bit positions inside the ALU flag vector
  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;

  // True when the condition code is satisfied by the current flags
  function automatic logic cond_met(input logic [2:0] cond, input logic [2:0] flags);
    logic result;
    result = 1'b0;
    case (cond)
      COND_ALWAYS: result = 1'b1;
      COND_Z:      result = flags[FLAG_Z];
      COND_C:      result = flags[FLAG_C];
      COND_N:      result = flags[FLAG_N];
      COND_NZ:     result = ~flags[FLAG_Z];
      COND_NC:     result = ~flags[FLAG_C];
      COND_NN:     result = ~flags[FLAG_N];
      default:     result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/micro_pc_reg.sv
// -----------------------------------------------------------------------------
// micro_pc_reg
// 8-bit program counter. Loads a jump target when load_en is high, otherwise
// increments (wrapping 8'hFF -> 8'h00) on every rising clock edge.
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset, forces pc to 8'h00
//   load_en    take load_value instead of incrementing
//   load_value jump target
//   pc         current program counter
// -----------------------------------------------------------------------------
module micro_pc_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       load_en,
  input  logic [7:0] load_value,
  output logic [7:0] pc
);

  // PC register; the 8-bit add wraps naturally at 8'hFF
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= 8'h00;
    end else if (load_en) begin
      pc <= load_value;
    end else begin
      pc <= pc + 8'd1;
    end
  end

endmodule

// File: rtl/micro_control_unit.sv
// -----------------------------------------------------------------------------
// micro_control_unit
// Control unit of the 8-bit teaching microprocessor. Decodes the 9-bit
// instruction combinationally into datapath controls and owns the PC.
// Ports:
//   clk                      system clock
//   rst                      asynchronous active-high reset
//   i_instruccion[8:0]       [8:6] opcode, [5:3] Rx, [2:0] Ry/Num/OP/Cond
//   Rx[7:0]                  value of register Sel_reg[5:3]; jump target
//   Ban[2:0]                 ALU flags: [0] zero, [1] carry, [2] negative
//   Sel_op[2:0]              ALU operation
//   Sel_reg[5:0]             register read selects: [5:3] port A, [2:0] port B
//   W                        data-memory write enable
//   Sel_outbus[1:0]          internal bus source
//   Sel_DW[2:0]              write-back register (000 = no write)
//   o_direccion_instruccion  program counter / instruction address
// -----------------------------------------------------------------------------
module micro_control_unit
  import micro_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [8:0] i_instruccion,
  input  logic [7:0] Rx,
  input  logic [2:0] Ban,
  output logic [2:0] Sel_op,
  output logic [5:0] Sel_reg,
  output logic       W,
  output logic [1:0] Sel_outbus,
  output logic [2:0] Sel_DW,
  output logic [7:0] o_direccion_instruccion
);

  logic [2:0] opcode;
  logic [2:0] field_x;
  logic [2:0] field_f;
  logic       jump_taken;

  assign opcode  = i_instruccion[8:6];
  assign field_x = i_instruccion[5:3];
  assign field_f = i_instruccion[2:0];

  // Instruction decode. Port A always follows the Rx field; reset suppresses
  // every write (memory and register file) while leaving the selects visible.
  always_comb begin
    Sel_op     = 3'b000;
    Sel_reg    = {field_x, 3'b000};
    W          = 1'b0;
    Sel_outbus = BUS_IMM;
    Sel_DW     = 3'b000;
    case (opcode)
      OP_LOAD_IMM: begin
        Sel_outbus = BUS_IMM;
        Sel_DW     = field_x;
      end
      OP_LOAD_MEM: begin
        Sel_reg[2:0] = field_f;
        Sel_outbus   = BUS_MEM;
        Sel_DW       = field_x;
      end
      OP_STORE_IMM: begin
        Sel_outbus = BUS_IMM;
        W          = 1'b1;
      end
      OP_STORE_REG: begin
        Sel_reg[2:0] = field_f;
        Sel_outbus   = BUS_REG;
        W            = 1'b1;
      end
      OP_MOVE: begin
        Sel_reg[2:0] = field_f;
        Sel_outbus   = BUS_REG;
        Sel_DW       = field_x;
      end
      OP_MATH: begin
        Sel_op     = field_f;
        Sel_outbus = BUS_ALU;
        Sel_DW     = field_x;
      end
      default: begin
      end
    endcase
    if (rst) begin
      W      = 1'b0;
      Sel_DW = 3'b000;
    end
  end

  assign jump_taken = (opcode == OP_JUMP) && cond_met(field_f, Ban);

  micro_pc_reg u_pc (
    .clk        (clk),
    .rst        (rst),
    .load_en    (jump_taken),
    .load_value (Rx),
    .pc         (o_direccion_instruccion)
  );

endmodule

// File: tb/tb_micro_control_unit.sv
// -----------------------------------------------------------------------------
// tb_micro_control_unit
// Self-checking bench: reset checks, a directed vector table, an async reset
// in mid-cycle, then random instructions against a behavioural model.
// -----------------------------------------------------------------------------
module tb_micro_control_unit;

  logic       clk;
  logic       rst;
  logic [8:0] i_instruccion;
  logic [7:0] Rx;
  logic [2:0] Ban;
  logic [2:0] Sel_op;
  logic [5:0] Sel_reg;
  logic       W;
  logic [1:0] Sel_outbus;
  logic [2:0] Sel_DW;
  logic [7:0] o_direccion_instruccion;

  int compared;
  int mismatched;
  int model_pc;

  micro_control_unit dut (
    .clk                     (clk),
    .rst                     (rst),
    .i_instruccion           (i_instruccion),
    .Rx                      (Rx),
    .Ban                     (Ban),
    .Sel_op                  (Sel_op),
    .Sel_reg                 (Sel_reg),
    .W                       (W),
    .Sel_outbus              (Sel_outbus),
    .Sel_DW                  (Sel_DW),
    .o_direccion_instruccion (o_direccion_instruccion)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Per-opcode properties of the instruction set, indexed by opcode
  logic [7:0] writes_reg_tbl = 8'b0011_0011;
  logic [7:0] writes_mem_tbl = 8'b0000_1100;
  logic [7:0] reads_b_tbl    = 8'b0001_1010;
  logic [1:0] bus_tbl [8]    = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11, 2'b00, 2'b00};

  // Expected {Sel_op, Sel_reg, W, Sel_outbus, Sel_DW}
  function automatic logic [14:0] model_decode(input logic [8:0] ins, input logic in_reset);
    logic [2:0] opc;
    logic [2:0] x;
    logic [2:0] f;
    logic [2:0] op;
    logic [5:0] reg_sel;
    logic       wr;
    logic [2:0] dw;
    opc     = ins[8:6];
    x       = ins[5:3];
    f       = ins[2:0];
    op      = (opc == 3'd5) ? f : 3'd0;
    reg_sel = {x, reads_b_tbl[opc] ? f : 3'd0};
    wr      = writes_mem_tbl[opc] & ~in_reset;
    dw      = (writes_reg_tbl[opc] && !in_reset) ? x : 3'd0;
    return {op, reg_sel, wr, bus_tbl[opc], dw};
  endfunction

  // Jump decision: codes 1-3 test a flag, 4-6 test its complement
  function automatic logic model_taken(input logic [8:0] ins, input logic [2:0] flags);
    int f;
    logic flag;
    if (ins[8:6] != 3'd6) return 1'b0;
    f = int'(ins[2:0]);
    if (f == 0) return 1'b1;
    if (f == 7) return 1'b0;
    flag = flags[(f - 1) % 3];
    return (f < 4) ? flag : ~flag;
  endfunction

  typedef struct {
    string      name;
    logic [8:0] ins;
    logic [2:0] ban;
    logic [7:0] rx;
    logic [2:0] exp_op;
    logic [5:0] exp_reg;
    logic       exp_w;
    logic [1:0] exp_bus;
    logic [2:0] exp_dw;
    logic [7:0] exp_pc;
  } vec_t;

  vec_t vecs [$];

  task automatic checkOutput(input string name, input logic [14:0] actual, input logic [14:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Called on a falling edge; drives inputs and lets the decode settle
  task automatic applyStimulus(input logic [8:0] ins, input logic [2:0] b, input logic [7:0] r);
    i_instruccion = ins;
    Ban           = b;
    Rx            = r;
    #1;
  endtask

  // Advance one clock, check the PC, and return on the next falling edge
  task automatic clockAndCheckPc(input string name, input logic [7:0] exp_pc);
    @(posedge clk);
    #1;
    checkOutput(name, {7'd0, o_direccion_instruccion}, {7'd0, exp_pc});
    @(negedge clk);
  endtask

  function automatic logic [14:0] dut_decode();
    return {Sel_op, Sel_reg, W, Sel_outbus, Sel_DW};
  endfunction

  initial begin
    logic [7:0] next_pc;
    compared   = 0;
    mismatched = 0;

    // Reset: writes are suppressed whatever the instruction
    rst = 1'b1;
    i_instruccion = 9'b000_001_100;
    Ban = 3'b000;
    Rx  = 8'h00;
    #2;
    checkOutput("reset_pc", {7'd0, o_direccion_instruccion}, 15'd0);
    checkOutput("reset_dw", {12'd0, Sel_DW}, 15'd0);
    i_instruccion = 9'b010_011_010;
    #1;
    checkOutput("reset_w", {14'd0, W}, 15'd0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(9'b111_100_001, 3'b000, 8'h00);
      checkOutput($sformatf("nop_decode_%0d", i), dut_decode(), {3'd0, 6'b100_000, 1'b0, 2'b00, 3'd0});
      clockAndCheckPc($sformatf("nop_pc_%0d", i), 8'(i));
    end

    // Directed vectors, applied back to back starting from PC=03
    vecs.push_back('{"load_imm",   9'b000_001_100, 3'b000, 8'hAA, 3'b000, 6'b001_000, 1'b0, 2'b00, 3'b001, 8'h04});
    vecs.push_back('{"load_mem",   9'b001_010_001, 3'b000, 8'hAA, 3'b000, 6'b010_001, 1'b0, 2'b10, 3'b010, 8'h05});
    vecs.push_back('{"move",       9'b100_001_010, 3'b000, 8'hAA, 3'b000, 6'b001_010, 1'b0, 2'b01, 3'b001, 8'h06});
    vecs.push_back('{"store_imm",  9'b010_011_010, 3'b000, 8'hAA, 3'b000, 6'b011_000, 1'b1, 2'b00, 3'b000, 8'h07});
    vecs.push_back('{"store_reg",  9'b011_111_110, 3'b000, 8'hAA, 3'b000, 6'b111_110, 1'b1, 2'b01, 3'b000, 8'h08});
    vecs.push_back('{"math",       9'b101_011_001, 3'b000, 8'hAA, 3'b001, 6'b011_000, 1'b0, 2'b11, 3'b011, 8'h09});
    vecs.push_back('{"jz_not",     9'b110_100_001, 3'b000, 8'h20, 3'b000, 6'b100_000, 1'b0, 2'b00, 3'b000, 8'h0A});
    vecs.push_back('{"jz_taken",   9'b110_100_001, 3'b001, 8'h40, 3'b000, 6'b100_000, 1'b0, 2'b00, 3'b000, 8'h40});
    vecs.push_back('{"jnz_not",    9'b110_000_100, 3'b001, 8'h80, 3'b000, 6'b000_000, 1'b0, 2'b00, 3'b000, 8'h41});
    vecs.push_back('{"jnever",     9'b110_000_111, 3'b111, 8'h90, 3'b000, 6'b000_000, 1'b0, 2'b00, 3'b000, 8'h42});
    vecs.push_back('{"jalways_ff", 9'b110_000_000, 3'b000, 8'hFF, 3'b000, 6'b000_000, 1'b0, 2'b00, 3'b000, 8'hFF});
    vecs.push_back('{"nop_wrap",   9'b111_100_001, 3'b000, 8'h00, 3'b000, 6'b100_000, 1'b0, 2'b00, 3'b000, 8'h00});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ins, vecs[i].ban, vecs[i].rx);
      checkOutput({vecs[i].name, "_decode"}, dut_decode(),
                  {vecs[i].exp_op, vecs[i].exp_reg, vecs[i].exp_w, vecs[i].exp_bus, vecs[i].exp_dw});
      clockAndCheckPc({vecs[i].name, "_pc"}, vecs[i].exp_pc);
    end

    // Async reset between edges while PC=05
    applyStimulus(9'b110_000_000, 3'b000, 8'h04);
    clockAndCheckPc("jump_to_04", 8'h04);
    applyStimulus(9'b010_001_000, 3'b000, 8'h00);
    clockAndCheckPc("pc_05", 8'h05);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_pc", {7'd0, o_direccion_instruccion}, 15'd0);
    checkOutput("async_rst_w", {14'd0, W}, 15'd0);
    @(posedge clk);
    #1;
    checkOutput("rst_hold_pc", {7'd0, o_direccion_instruccion}, 15'd0);
    @(negedge clk);
    rst = 1'b0;
    model_pc = 0;

    // Random instructions against the behavioural model
    for (int n = 0; n < 300; n++) begin
      applyStimulus(9'($urandom_range(0, 511)), 3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)));
      checkOutput($sformatf("rand_decode_%0d", n), dut_decode(), model_decode(i_instruccion, 1'b0));
      next_pc = model_taken(i_instruccion, Ban) ? Rx : 8'((model_pc + 1) % 256);
      clockAndCheckPc($sformatf("rand_pc_%0d", n), next_pc);
      model_pc = int'(next_pc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
